// File: rtl/multicycle_ctrl_if.sv
// Control/status bundle between the multicycle controller and its datapath.
// master = controller side, slave = datapath (or bench) side.
interface multicycle_ctrl_if;
  logic [5:0]  opcode;
  logic [5:0]  funct;
  logic        mem_ready;
  logic        mem_req;
  logic        mem_we;
  logic        iord;
  logic        ir_write;
  logic        pc_write;
  logic        pc_write_cond;
  logic        reg_write;
  logic [1:0]  reg_dst;
  logic [1:0]  mem_to_reg;
  logic        alu_src_a;
  logic [1:0]  alu_src_b;
  logic [2:0]  alu_op;
  logic [1:0]  pc_source;
  logic [1:0]  branch_type;
  logic [2:0]  state;
  logic        err;
  logic [31:0] retire_cnt;

  modport master (
    input  opcode, funct, mem_ready,
    output mem_req, mem_we, iord, ir_write, pc_write, pc_write_cond, reg_write,
           reg_dst, mem_to_reg, alu_src_a, alu_src_b, alu_op, pc_source,
           branch_type, state, err, retire_cnt
  );
  modport slave (
    output opcode, funct, mem_ready,
    input  mem_req, mem_we, iord, ir_write, pc_write, pc_write_cond, reg_write,
           reg_dst, mem_to_reg, alu_src_a, alu_src_b, alu_op, pc_source,
           branch_type, state, err, retire_cnt
  );
endinterface

// File: rtl/multicycle_ctrl.sv
// Multicycle MIPS-subset controller: IF/ID/EX/MEM/WB sequencing with a
// shared-memory wait timeout, sticky error state and retired-instruction count.
module multicycle_ctrl #(
  parameter int TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst_n,
  multicycle_ctrl_if.master bus
);
  localparam logic [2:0] S_IF = 3'd0, S_ID = 3'd1, S_EX = 3'd2,
                         S_MEM = 3'd3, S_WB = 3'd4, S_ERR = 3'd5;
  localparam logic [5:0] OP_R = 6'b000000, OP_ADDI = 6'b001000, OP_SLTI = 6'b001010,
                         OP_LW = 6'b100011, OP_SW = 6'b101011, OP_BEQ = 6'b000100,
                         OP_BNE = 6'b000101, OP_J = 6'b000010, OP_JAL = 6'b000011;
  localparam logic [5:0] FN_JR = 6'b001000;
  localparam int WW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [WW-1:0] WAIT_LAST = WW'(TIMEOUT - 1);

  logic [2:0]    state, state_nxt;
  logic [WW-1:0] wait_cnt, wait_nxt;
  logic [31:0]   retire_cnt;
  logic          is_r, is_jr, is_lw, is_sw;

  assign is_r  = bus.opcode == OP_R;
  assign is_jr = is_r && (bus.funct == FN_JR);
  assign is_lw = bus.opcode == OP_LW;
  assign is_sw = bus.opcode == OP_SW;

  // Wait counter only advances on not-ready cycles of the two memory states;
  // any other path leaves it at zero.
  always_comb begin
    state_nxt = state;
    wait_nxt  = '0;
    case (state)
      S_IF, S_MEM: begin
        if (bus.mem_ready) begin
          if (state == S_IF) state_nxt = S_ID;
          else               state_nxt = is_lw ? S_WB : S_IF;
        end else if (wait_cnt == WAIT_LAST) begin
          state_nxt = S_ERR;
        end else begin
          wait_nxt = wait_cnt + 1'b1;
        end
      end
      S_ID: begin
        case (bus.opcode)
          OP_R:                                     state_nxt = is_jr ? S_IF : S_EX;
          OP_ADDI, OP_SLTI, OP_LW, OP_SW, OP_BEQ, OP_BNE: state_nxt = S_EX;
          default:                                  state_nxt = S_IF;
        endcase
      end
      S_EX: begin
        case (bus.opcode)
          OP_R, OP_ADDI, OP_SLTI: state_nxt = S_WB;
          OP_LW, OP_SW:           state_nxt = S_MEM;
          default:                state_nxt = S_IF;
        endcase
      end
      S_WB:    state_nxt = S_IF;
      S_ERR:   state_nxt = S_ERR;
      default: state_nxt = S_IF;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IF;
      wait_cnt   <= '0;
      retire_cnt <= '0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_nxt;
      if (state_nxt == S_IF && state inside {S_ID, S_EX, S_MEM, S_WB})
        retire_cnt <= retire_cnt + 32'd1;
    end
  end

  always_comb begin
    bus.mem_req       = 1'b0;
    bus.mem_we        = 1'b0;
    bus.iord          = 1'b0;
    bus.ir_write      = 1'b0;
    bus.pc_write      = 1'b0;
    bus.pc_write_cond = 1'b0;
    bus.reg_write     = 1'b0;
    bus.reg_dst       = 2'd0;
    bus.mem_to_reg    = 2'd0;
    bus.alu_src_a     = 1'b0;
    bus.alu_src_b     = 2'd0;
    bus.alu_op        = 3'b000;
    bus.pc_source     = 2'd0;
    bus.branch_type   = 2'd0;
    case (state)
      S_IF: begin
        bus.mem_req   = 1'b1;
        bus.alu_src_b = 2'd1;
        bus.ir_write  = bus.mem_ready;
        bus.pc_write  = bus.mem_ready;
      end
      S_ID: begin
        bus.alu_src_b = 2'd3;
        if (bus.opcode == OP_J || bus.opcode == OP_JAL) begin
          bus.pc_write  = 1'b1;
          bus.pc_source = 2'd2;
        end
        if (bus.opcode == OP_JAL) begin
          bus.reg_write  = 1'b1;
          bus.reg_dst    = 2'd2;
          bus.mem_to_reg = 2'd3;
        end
        if (is_jr) begin
          bus.pc_write  = 1'b1;
          bus.pc_source = 2'd3;
        end
      end
      S_EX: begin
        bus.alu_src_a = 1'b1;
        case (bus.opcode)
          OP_R:    bus.alu_op = 3'b010;
          OP_ADDI, OP_LW, OP_SW: bus.alu_src_b = 2'd2;
          OP_SLTI: begin bus.alu_src_b = 2'd2; bus.alu_op = 3'b011; end
          OP_BEQ, OP_BNE: begin
            bus.alu_op        = 3'b001;
            bus.pc_write_cond = 1'b1;
            bus.pc_source     = 2'd1;
            bus.branch_type   = (bus.opcode == OP_BNE) ? 2'd3 : 2'd0;
          end
          default: ;
        endcase
      end
      S_MEM: begin
        bus.mem_req = 1'b1;
        bus.iord    = 1'b1;
        bus.mem_we  = is_sw;
      end
      S_WB: begin
        bus.reg_write  = 1'b1;
        bus.mem_to_reg = is_lw ? 2'd1 : 2'd0;
        bus.reg_dst    = is_r ? 2'd1 : 2'd0;
      end
      default: ;
    endcase
    // Reset must silence the memory port and strobes even though state reads IF.
    if (!rst_n) begin
      bus.mem_req       = 1'b0;
      bus.mem_we        = 1'b0;
      bus.ir_write      = 1'b0;
      bus.pc_write      = 1'b0;
      bus.pc_write_cond = 1'b0;
      bus.reg_write     = 1'b0;
    end
  end

  assign bus.state      = state;
  assign bus.err        = state == S_ERR;
  assign bus.retire_cnt = retire_cnt;
endmodule

// File: doc/multicycle_ctrl.md
MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 Parameter: TIMEOUT, default 15, max consecutive not-ready cycles tolerated in a memory-wait state.
REQ-002 clk_i  in  1  sole clock; all state updates on rising edge.
REQ-003 rst_i  in  1  asynchronous, active-low reset.
REQ-004 opcode_i  in  6  instr[31:26] from the instruction register; stable from ID onward.
REQ-005 funct_i  in  6  instr[5:0] from the instruction register.
REQ-006 mem_ready_i  in  1  shared memory completes the current request this cycle.
REQ-007 mem_req_o, mem_we_o, iord_o  out  1 each  memory request, write enable, address select (0=PC, 1=ALU result register).
REQ-008 ir_write_o, pc_write_o, pc_write_cond_o, reg_write_o  out  1 each  register-update strobes.
REQ-009 reg_dst_o  out  2  0=rt, 1=rd, 2=r31.
REQ-010 mem_to_reg_o  out  2  0=ALU result, 1=memory data, 3=PC.
REQ-011 alu_src_a_o  out  1  0=PC, 1=RS.
REQ-012 alu_src_b_o  out  2  0=RT, 1=const 4, 2=sign-extended imm, 3=imm<<2.
REQ-013 alu_op_o  out  3  000 add, 001 sub, 010 R-type (funct decoded downstream), 011 slt.
REQ-014 pc_source_o, branch_type_o  out  2 each  PC source 0=ALU, 1=ALU-out register, 2=jump target, 3=RS; branch type 0=eq, 3=ne.
REQ-015 state_o  out  3  current state; err_o  out  1  sticky timeout flag; retire_cnt_o  out  32  retired-instruction count.

Function
REQ-016 States: IF=0, ID=1, EX=2, MEM=3, WB=4, ERR=5; all outputs are Moore/decoded from state, opcode_i, funct_i, mem_ready_i; unlisted strobes are 0.
REQ-017 Opcodes: R 000000, addi 001000, slti 001010, lw 100011, sw 101011, beq 000100, bne 000101, j 000010, jal 000011; jr = R with funct 001000.
REQ-018 IF: mem_req_o=1, iord_o=0, alu_src_a=0, alu_src_b=1, alu_op=000, pc_source=0; when mem_ready_i=1, ir_write_o=1, pc_write_o=1, next ID; otherwise stay in IF.
REQ-019 ID: alu_src_a=0, alu_src_b=3, alu_op=000 (branch target precompute).
REQ-020 ID, j: pc_write_o=1, pc_source=2, next IF.
REQ-021 ID, jal: same as j, plus reg_write_o=1, reg_dst=2, mem_to_reg=3, next IF.
REQ-022 ID, jr: pc_write_o=1, pc_source=3, next IF.
REQ-023 ID, unknown opcode: no strobes, next IF (NOP).
REQ-024 ID, all other opcodes: next EX.
REQ-025 EX, R: alu_src_a=1, alu_src_b=0, alu_op=010, next WB.
REQ-026 EX, addi/slti: alu_src_a=1, alu_src_b=2, alu_op 000/011, next WB.
REQ-027 EX, lw/sw: alu_src_a=1, alu_src_b=2, alu_op=000, next MEM.
REQ-028 EX, beq/bne: alu_src_a=1, alu_src_b=0, alu_op=001, pc_write_cond_o=1, pc_source=1, branch_type 0/3, next IF.
REQ-029 MEM: mem_req_o=1, iord_o=1, mem_we_o=1 for sw only; on mem_ready_i: lw next WB, sw next IF; otherwise hold all MEM outputs.
REQ-030 WB: reg_write_o=1, mem_to_reg 0 (R/addi/slti) or 1 (lw), reg_dst 1 (R) or 0 (otherwise), next IF.
REQ-031 Wait counter: increments each IF/MEM cycle with mem_ready_i=0; clears on ready or on leaving the state; when it reaches TIMEOUT with ready still 0, next state ERR.
REQ-032 ERR: err_o=1, all strobes and mem_req_o 0, state held until reset.
REQ-033 retire_cnt_o: +1 on every transition into IF from ID, EX, MEM or WB; wraps 0xFFFFFFFF->0; never increments in ERR.
REQ-034 mem_ready_i ignored outside IF/MEM.

Reset
REQ-035 rst_i=0 asynchronously forces state IF, wait counter 0, err_o 0, retire_cnt_o 0, and drives all strobes and mem_req_o to 0 while asserted.
REQ-036 Reset mid-memory-wait abandons the request; first edge after release begins a fresh IF.

Verification
REQ-037 add (R), mem_ready_i always 1 -> states IF,ID,EX,WB; reg_write_o=1, reg_dst=1 only in WB; retire_cnt_o=1 after 4 cycles.
REQ-038 lw, ready delayed 3 cycles in IF and 2 in MEM -> 10 cycles total; ir_write_o pulses once; WB mem_to_reg=1.
REQ-039 beq -> 3 cycles; EX shows pc_write_cond_o=1, alu_op=001, pc_source=1; next state IF.
REQ-040 jal -> 2 cycles; ID shows reg_dst=2, mem_to_reg=3, pc_source=2, reg_write_o=1.
REQ-041 TIMEOUT=15, mem_ready_i held 0 -> ERR after 15 wait cycles; err_o=1, mem_req_o=0; retire_cnt_o unchanged.
REQ-042 rst_i pulsed low during MEM of sw -> outputs 0 immediately; after release IF with retire_cnt_o=0, err_o=0.
